// File: rtl/kanagawa_sim_fifo_write_to_mailbox_pkg.sv
// kanagawa_sim_fifo_write_to_mailbox_pkg: staller policies and almost-full threshold helper
package kanagawa_sim_fifo_write_to_mailbox_pkg;
  typedef enum logic {NullStallPolicy, RandomStallPolicy} stall_policy_e;
  localparam int unsigned STORE_BITS = 11;
  function automatic int unsigned af_threshold(input int unsigned depth, input int unsigned slack);
    return depth > slack ? depth - slack : 0;
  endfunction
endpackage

// File: rtl/kanagawa_sim_fifo_write_to_mailbox_staller.sv
// kanagawa_sim_fifo_write_to_mailbox_staller: seeded LFSR backpressure source
module kanagawa_sim_fifo_write_to_mailbox_staller
  import kanagawa_sim_fifo_write_to_mailbox_pkg::*;
#(
  parameter stall_policy_e POLICY = NullStallPolicy,
  parameter int unsigned SEED = 0
) (
  input  logic clk,
  input  logic rst,
  output logic stalled_out
);
  localparam logic [15:0] MIXED = SEED[15:0] ^ 16'hace1;
  localparam logic [15:0] INIT = MIXED == 16'h0 ? 16'h1 : MIXED;
  logic [15:0] lfsr = INIT;
  always_ff @(posedge clk)
    lfsr <= rst ? INIT : {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign stalled_out = POLICY == RandomStallPolicy && lfsr[1:0] == 2'b00;
endmodule

// File: rtl/kanagawa_sim_fifo_write_to_mailbox.sv
// kanagawa_sim_fifo_write_to_mailbox: FIFO write-side mock depositing items into a drainable store
module kanagawa_sim_fifo_write_to_mailbox
  import kanagawa_sim_fifo_write_to_mailbox_pkg::*;
#(
  parameter type T = logic [31:0],
  parameter int unsigned DEPTH = 0,
  parameter int unsigned ALMOST_FULL_SLACK = 2,
  parameter bit CLEAR_ON_RESET = 1,
  parameter stall_policy_e STALL_POLICY = NullStallPolicy,
  parameter int unsigned STALLER_SEED = 0,
  parameter bit FATAL_ON_OVERFLOW = 0,
  parameter bit REPORT_OVERFLOW = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wren_in,
  input  logic [$bits(T)-1:0]  wrdata_in,
  output logic                 full_out,
  output logic                 almost_full_out,
  output logic                 overflow_out
);
  localparam int unsigned AF_THRESHOLD = af_threshold(DEPTH, ALMOST_FULL_SLACK);
  localparam int unsigned STORE = 1 << STORE_BITS;
  T mem [STORE];
  int unsigned wr_cnt = 0;
  int unsigned clr_mark = 0;
  int unsigned rd_cnt = 0;
  int unsigned ovf_cnt = 0;
  int unsigned head;
  int unsigned occ_n;
  logic full_q = 1'b1;
  logic af_q = 1'b0;
  logic ovf_q = 1'b0;
  logic stall;
  logic accept;
  kanagawa_sim_fifo_write_to_mailbox_staller #(.POLICY(STALL_POLICY), .SEED(STALLER_SEED)) staller (
    .clk(clk),
    .rst(rst),
    .stalled_out(stall)
  );
  // reads are consumed by advancing rd_cnt; a reset clear advances clr_mark instead
  assign head = rd_cnt > clr_mark ? rd_cnt : clr_mark;
  assign accept = wren_in && !full_q;
  assign occ_n = wr_cnt - head + {31'b0, accept};
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b1;
      af_q <= 1'b0;
      ovf_q <= 1'b0;
      ovf_cnt <= 0;
      if (CLEAR_ON_RESET) clr_mark <= wr_cnt;
    end else begin
      if (accept) begin
        mem[wr_cnt[STORE_BITS-1:0]] <= T'(wrdata_in);
        wr_cnt <= wr_cnt + 1;
      end
      // the backing store is finite, so it backpressures even when DEPTH is unlimited
      full_q <= stall || (DEPTH != 0 && occ_n >= DEPTH) || occ_n >= STORE;
      af_q <= DEPTH != 0 && occ_n >= AF_THRESHOLD;
      if (wren_in && full_q) begin
        ovf_q <= 1'b1;
        ovf_cnt <= ovf_cnt + 1;
        if (REPORT_OVERFLOW) begin
          if (FATAL_ON_OVERFLOW) $fatal(1, "fifo write overflow at %0t", $time);
          else $error("fifo write overflow at %0t", $time);
        end
      end
    end
  end
  assign full_out = full_q;
  assign almost_full_out = af_q;
  assign overflow_out = ovf_q;
  function automatic int unsigned cur_head();
    return rd_cnt > clr_mark ? rd_cnt : clr_mark;
  endfunction
  function automatic int num();
    return int'(wr_cnt - cur_head());
  endfunction
  function automatic logic is_empty();
    return num() == 0;
  endfunction
  function automatic int overflow_count();
    return int'(ovf_cnt);
  endfunction
  function automatic logic try_peek(output T v);
    int unsigned h;
    h = cur_head();
    v = mem[h[STORE_BITS-1:0]];
    return num() != 0;
  endfunction
  function automatic logic try_get(output T v);
    if (!try_peek(v)) return 1'b0;
    rd_cnt = cur_head() + 1;
    return 1'b1;
  endfunction
  function automatic void clear();
    rd_cnt = wr_cnt;
  endfunction
  task automatic get(output T v);
    while (is_empty()) @(negedge clk);
    void'(try_get(v));
  endtask
endmodule

// File: tb/tb_kanagawa_sim_fifo_write_to_mailbox.sv
// tb_kanagawa_sim_fifo_write_to_mailbox: directed checks across four parameterisations
module tb_kanagawa_sim_fifo_write_to_mailbox;
  import kanagawa_sim_fifo_write_to_mailbox_pkg::*;
  logic clk = 1'b0;
  logic rst_a, rst_b, rst_c, rst_d;
  logic wren_a, wren_b, wren_c, wren_d;
  logic [31:0] wd_a, wd_b, wd_c, wd_d;
  logic full_a, full_b, full_c, full_d;
  logic af_a, af_b, af_c, af_d;
  logic ovf_a, ovf_b, ovf_c, ovf_d;
  logic [31:0] v;
  logic ok, saw;
  int checks = 0, failures = 0, bad, n, cyc;
  always #5 clk = ~clk;
  kanagawa_sim_fifo_write_to_mailbox #(.DEPTH(0)) dut_a (
    .clk(clk), .rst(rst_a), .wren_in(wren_a), .wrdata_in(wd_a),
    .full_out(full_a), .almost_full_out(af_a), .overflow_out(ovf_a));
  kanagawa_sim_fifo_write_to_mailbox #(.DEPTH(4), .ALMOST_FULL_SLACK(2), .REPORT_OVERFLOW(0)) dut_b (
    .clk(clk), .rst(rst_b), .wren_in(wren_b), .wrdata_in(wd_b),
    .full_out(full_b), .almost_full_out(af_b), .overflow_out(ovf_b));
  kanagawa_sim_fifo_write_to_mailbox #(.STALL_POLICY(RandomStallPolicy), .STALLER_SEED(7)) dut_c (
    .clk(clk), .rst(rst_c), .wren_in(wren_c), .wrdata_in(wd_c),
    .full_out(full_c), .almost_full_out(af_c), .overflow_out(ovf_c));
  kanagawa_sim_fifo_write_to_mailbox #(.CLEAR_ON_RESET(0)) dut_d (
    .clk(clk), .rst(rst_d), .wren_in(wren_d), .wrdata_in(wd_d),
    .full_out(full_d), .almost_full_out(af_d), .overflow_out(ovf_d));
  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  initial begin
    {rst_a, rst_b, rst_c, rst_d} = 4'hf;
    {wren_a, wren_b, wren_c, wren_d} = 4'h0;
    wd_a = 0; wd_b = 0; wd_c = 0; wd_d = 0;
    #1;
    chk("init_full", full_a, 1);
    chk("init_af", af_b, 0);
    chk("init_ovf", ovf_a, 0);
    repeat (2) @(negedge clk);
    chk("rst_full", full_b, 1);
    {rst_a, rst_b, rst_c, rst_d} = 4'h0;
    chk("first_post_rst_full", full_a, 1);
    @(negedge clk);
    chk("full_released", full_a, 0);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      wren_a = 1; wd_a = 32'(i);
      @(negedge clk);
      if (full_a) bad++;
    end
    wren_a = 0;
    chk("t1_full_low", bad, 0);
    chk("t1_num", dut_a.num(), 100);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      ok = dut_a.try_get(v);
      if (!ok || v !== 32'(i)) bad++;
    end
    chk("t1_order", bad, 0);
    chk("t1_drained", dut_a.num(), 0);
    wren_b = 1; wd_b = 1; @(negedge clk);
    chk("t2_af_after1", af_b, 0);
    wd_b = 2; @(negedge clk);
    chk("t2_af_after2", af_b, 1);
    wd_b = 3; @(negedge clk);
    chk("t2_full_after3", full_b, 0);
    wd_b = 4; @(negedge clk);
    wren_b = 0;
    chk("t2_full_after4", full_b, 1);
    dut_b.get(v);
    chk("t2_get_val", v, 1);
    chk("t2_full_same_step", full_b, 1);
    @(negedge clk);
    chk("t2_full_drained", full_b, 0);
    chk("t2_af_occ3", af_b, 1);
    wren_b = 1; wd_b = 5; @(negedge clk);
    wren_b = 0;
    chk("t3_full_refill", full_b, 1);
    wren_b = 1; wd_b = 32'hdead; @(negedge clk);
    wren_b = 0;
    chk("t3_ovf", ovf_b, 1);
    chk("t3_ovf_count", dut_b.overflow_count(), 1);
    chk("t3_num", dut_b.num(), 4);
    @(negedge clk);
    chk("t3_ovf_sticky", ovf_b, 1);
    bad = 0;
    for (int i = 2; i <= 5; i++) begin
      ok = dut_b.try_get(v);
      if (!ok || v !== 32'(i)) bad++;
    end
    chk("t3_contents", bad, 0);
    ok = dut_b.try_get(v);
    chk("t3_try_get_empty", ok, 0);
    chk("t3_is_empty", dut_b.is_empty(), 1);
    n = 0; saw = 0; cyc = 0;
    while (n < 1000 && cyc < 5000) begin
      if (full_c) begin
        wren_c = 0; saw = 1;
      end else begin
        wren_c = 1; wd_c = 32'(n); n++;
      end
      @(negedge clk);
      cyc++;
    end
    wren_c = 0;
    chk("t4_sent", n, 1000);
    chk("t4_num", dut_c.num(), 1000);
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      ok = dut_c.try_get(v);
      if (!ok || v !== 32'(i)) bad++;
    end
    chk("t4_order", bad, 0);
    chk("t4_no_ovf", ovf_c, 0);
    chk("t4_saw_full", saw, 1);
    for (int i = 0; i < 3; i++) begin
      wren_a = 1; wd_a = 32'(10 + i); @(negedge clk);
    end
    chk("t5_loaded", dut_a.num(), 3);
    rst_a = 1; wren_a = 1; wd_a = 77;
    repeat (2) @(negedge clk);
    rst_a = 0; wren_a = 0;
    chk("t5_num_cleared", dut_a.num(), 0);
    chk("t5_full_post_rst", full_a, 1);
    chk("t5_no_ovf", ovf_a, 0);
    @(negedge clk);
    chk("t5_full_release", full_a, 0);
    chk("t5_ovf_count", dut_a.overflow_count(), 0);
    for (int i = 0; i < 3; i++) begin
      wren_d = 1; wd_d = 32'(21 + i); @(negedge clk);
    end
    wren_d = 0; rst_d = 1;
    repeat (2) @(negedge clk);
    rst_d = 0;
    chk("t6_num_kept", dut_d.num(), 3);
    chk("t6_no_ovf", ovf_d, 0);
    @(negedge clk);
    wren_d = 1; wd_d = 24; @(negedge clk);
    wren_d = 0;
    bad = 0;
    for (int i = 21; i <= 24; i++) begin
      ok = dut_d.try_get(v);
      if (!ok || v !== 32'(i)) bad++;
    end
    chk("t6_append_order", bad, 0);
    chk("t6_drained", dut_d.num(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/kanagawa_sim_fifo_write_to_mailbox.md
# kanagawa_sim_fifo_write_to_mailbox

Simulation-only mock of the write side of a FIFO: the DUT pushes items through a registered full/wren handshake, and the block deposits them into a mailbox that testbench code drains through a task/function API. Optional stall injection via a staller policy models realistic backpressure. The block is the sink end of DUT output FIFOs in unit benches, and the counterpart of the mailbox-fed FIFO read mock.

## Interface
- T, no default: strongly-typed item type.
- DEPTH, 0: modelled capacity; 0 = unlimited, so capacity never drives full_out.
- ALMOST_FULL_SLACK, 2: almost_full_out asserts when occupancy >= DEPTH - ALMOST_FULL_SLACK. Ignored when DEPTH = 0.
- CLEAR_ON_RESET, 1: reset empties the mailbox.
- STALL_POLICY, NullStallPolicy: staller policy type from KanagawaSimStallerPolicies.
- STALLER_SEED, 0: staller seed.
- FATAL_ON_OVERFLOW, 0: 1 = $fatal on overflow; 0 = $error.

Ports (one clock; reset is synchronous and active-high):
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- wren_in  input  1  write request, sampled at posedge
- wrdata_in  input  $bits(T)  item written when wren_in is high
- full_out  output  1  registered full; the writer must not assert wren_in while it is high
- almost_full_out  output  1  registered almost-full
- overflow_out  output  1  sticky: a write was attempted while full_out was high

## Operation
- Accept: at a posedge with rst=0, wren_in=1 and full_out=0, push wrdata_in into the mailbox with a non-blocking put. The item is visible to num()/try_get() after that edge.
- Overflow: wren_in=1 while full_out=1.
  - The item is dropped and overflow_out is set.
  - The internal overflow counter increments.
  - $error or $fatal is issued with the simulation time.
- Occupancy occ = mailbox count after this edge's push.
- Next full_out = stall OR (DEPTH != 0 AND occ >= DEPTH).
- Next almost_full_out = DEPTH != 0 AND occ >= DEPTH - ALMOST_FULL_SLACK, with the subtraction saturating at 0.
- Testbench gets between edges are reflected at the next edge's evaluation. Full deasserts one edge after a drain. The block never relies on the mailbox blocking.
- Reset (rst=1 at posedge):
  - full_out <= 1, almost_full_out <= 0, overflow_out <= 0, overflow counter <= 0.
  - If CLEAR_ON_RESET, the mailbox is cleared.
  - wren_in is ignored and is not an overflow.
  - Reset mid-traffic discards the in-flight write of that cycle.
- Initial values before the first edge: full_out=1, almost_full_out=0, overflow_out=0.
- User API:
  - num(): int.
  - try_get(output T): bit.
  - get(output T): blocking task.
  - try_peek(output T): bit.
  - clear().
  - is_empty(): bit.
  - overflow_count(): int.
  - clear() does not touch overflow state.

## Timing
- Write latency: 0 cycles to the mailbox, so the item is gettable in the same timestep after the accepting edge.
- Stall asserted by the staller in cycle n gives full_out=1 in cycle n+1. A write in cycle n is still accepted.
- With DEPTH=D: the edge that makes occ=D raises full_out in the following cycle. The writer sees full one cycle after its D-th write, as with a registered FIFO full flag.
- First cycle after rst falls: full_out is still 1 (registered). It takes its computed value from the second post-reset edge.
- Simultaneous stall and capacity-full: full_out=1. Deasserts only when both clear.

## Structure
- Package: reuse KanagawaSimStallerPolicies. No new typedefs. Add a localparam for the saturated almost-full threshold.
- Sub-module KanagawaSimStaller (existing): instance staller, .stalled_out drives stall.
- Backing store: the codebase mailbox interface parameterised #(T, 0). DEPTH is enforced by full logic here, not by the mailbox bound.

## Test plan
- T=logic[31:0], DEPTH=0, NullStallPolicy. Write 0..99 on consecutive cycles. -> full_out stays 0 after reset; try_get returns 0..99 in order; num()=0 after draining.
- DEPTH=4, ALMOST_FULL_SLACK=2. Write 1,2,3,4 back-to-back, no drain. -> almost_full_out=1 the cycle after writing 2; full_out=1 the cycle after writing 4. get() one item -> full_out=0 one edge later.
- DEPTH=4 full. Force wren_in=1 with data 0xDEAD. -> overflow_out=1 next cycle; overflow_count()=1; num()=4; 0xDEAD is never returned.
- Random STALL_POLICY, seed 7, 1000 writes by a compliant writer (honours full_out). -> all 1000 received in order; overflow_out=0; full_out observed high at least once.
- Load 3 items, then assert rst for 2 cycles with wren_in=1. -> num()=0 (CLEAR_ON_RESET=1); full_out=1 through the first post-reset cycle; no overflow flagged.
- CLEAR_ON_RESET=0. Load 3 items, then reset. -> num()=3; overflow_out=0; subsequent writes are appended after the retained items.
